button_sequencer: RTL and testbench
===================================

BUTTON_SEQUENCER -- requirements
Module: button_sequencer

Interface
REQ-001 Parameter long_press_count, 16'd2000: cycles startstop must be held to issue reset instead of start/stop; legal 1..65535.
REQ-002 Parameter repeat_delay, 16'd500: cycles from first increment pulse to first auto-repeat pulse; legal 1..65535.
REQ-003 Parameter repeat_period, 16'd100: cycles between auto-repeat pulses; legal 1..65535.
REQ-004 clk  input  1  single system clock (1 kHz domain); all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 button_startstop_n  input  1  synchronised start/stop button level, 0 = pressed.
REQ-007 button_min_n  input  1  synchronised minute button level, 0 = pressed.
REQ-008 button_sec_n  input  1  synchronised second button level, 0 = pressed.
REQ-009 ctrl_startstop  output  1  one-cycle start/stop strobe to timer.
REQ-010 ctrl_reset  output  1  one-cycle timer reset strobe.
REQ-011 ctrl_incmin  output  1  one-cycle minute-increment strobe.
REQ-012 ctrl_incsec  output  1  one-cycle second-increment strobe.

Function
REQ-013 Each button input SHALL be registered once; press = registered value 1->0, release = 0->1; all timing below counts from the edge where the new value is registered (cycle 0).
REQ-014 All four outputs SHALL be registered, at most one asserted in any cycle, each high for exactly one cycle per grant.
REQ-015 Startstop FSM SHALL have states SS_IDLE, SS_HELD, SS_LONG: press -> SS_HELD with hold counter cleared; counter increments each held cycle.
REQ-016 In SS_HELD, release before counter reaches long_press_count SHALL post one startstop request and return to SS_IDLE.
REQ-017 In SS_HELD, counter reaching long_press_count SHALL post one reset request and enter SS_LONG; release in SS_LONG returns to SS_IDLE with no startstop request.
REQ-018 Each increment button SHALL have its own FSM IDLE, DELAY, REPEAT with a 16-bit counter: press posts a request and enters DELAY.
REQ-019 DELAY: after repeat_delay held cycles post a request and enter REPEAT; REPEAT: post a request every repeat_period held cycles.
REQ-020 Release in any increment state SHALL return to IDLE immediately, clear its counter, post nothing.
REQ-021 Posted requests SHALL set per-output pending flags; each cycle the highest-priority pending flag is granted (reset > startstop > incmin > incsec), its output pulses next cycle, flag clears.
REQ-022 Non-granted pending flags SHALL persist (no request lost); a request posted while the same flag is still pending SHALL merge into one pulse.
REQ-023 Unobstructed latency SHALL be one cycle: request posted at cycle 0 -> strobe high during cycle 1.
REQ-024 Counters SHALL saturate, never wrap; SS_LONG held indefinitely issues no further requests.

Reset
REQ-025 reset low SHALL immediately force all outputs 0, all FSMs idle, counters 0, pending flags clear, input registers 1 (released).
REQ-026 A button still held when reset deasserts SHALL be treated as a fresh press on the first registered edge.

Verification (long_press_count=8, repeat_delay=6, repeat_period=3)
REQ-027 Startstop held 3 cycles -> single ctrl_startstop pulse 1 cycle after release registered; ctrl_reset never asserted.
REQ-028 Startstop held 20 cycles -> single ctrl_reset at cycle 9 (posted at 8); no ctrl_startstop on release.
REQ-029 Min held cycles 0..14 -> ctrl_incmin pulses at cycles 1, 7, 10, 13 only; ctrl_incsec stays 0.
REQ-030 Min and sec pressed same edge -> ctrl_incmin at cycle 1, ctrl_incsec at cycle 2, never overlapping.
REQ-031 Startstop long-press reset request coinciding with sec repeat request -> ctrl_reset first, ctrl_incsec next cycle.
REQ-032 reset pulsed low mid-hold of min -> outputs 0 during reset; after release with button held, ctrl_incmin at cycle 1 and repeat timing restarts.

Source files
------------

// File: rtl/button_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : button_sequencer
// Purpose  : Turns three synchronised active-low buttons into one-cycle,
//            mutually exclusive timer control strobes. The strobes are
//            start/stop, reset, increment-minute and increment-second.
// Revision : 1.0 - initial release
// =============================================================================
module button_sequencer #(
    parameter logic [15:0] long_press_count = 16'd2000,
    parameter logic [15:0] repeat_delay     = 16'd500,
    parameter logic [15:0] repeat_period    = 16'd100
) (
    input  logic clk,
    input  logic reset,
    input  logic button_startstop_n,
    input  logic button_min_n,
    input  logic button_sec_n,
    output logic ctrl_startstop,
    output logic ctrl_reset,
    output logic ctrl_incmin,
    output logic ctrl_incsec
);

    typedef enum logic [1:0] {
        SS_IDLE = 2'd0,
        SS_HELD = 2'd1,
        SS_LONG = 2'd2
    } ss_state_t;

    typedef enum logic [1:0] {
        INC_IDLE   = 2'd0,
        INC_DELAY  = 2'd1,
        INC_REPEAT = 2'd2
    } inc_state_t;

    // Request / pending / strobe vectors share one bit layout, highest priority first.
    localparam int unsigned c_BIT_RESET = 3;
    localparam int unsigned c_BIT_SS    = 2;
    localparam int unsigned c_BIT_MIN   = 1;
    localparam int unsigned c_BIT_SEC   = 0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Button levels: [2] startstop, [1] min, [0] sec; 1 = released.
    logic [2:0]  btn_q;
    logic [2:0]  btn_prev_q;
    logic [2:0]  press_w;

    ss_state_t   ss_state_q;
    ss_state_t   ss_state_d;
    logic [15:0] ss_cnt_q;
    logic [15:0] ss_cnt_d;
    logic        ss_req_w;
    logic        rst_req_w;

    logic [1:0]  inc_req_w;
    logic [3:0]  req_w;
    logic [3:0]  pend_q;
    logic [3:0]  pend_all_w;
    logic [3:0]  pend_d;
    logic [3:0]  grant_w;
    logic [3:0]  strobe_q;

    assign press_w = btn_prev_q & ~btn_q;

    // -------------------------------------------------------------------------
    // Start/stop: short press toggles the timer, long press resets it.
    // -------------------------------------------------------------------------
    always_comb begin
        ss_state_d = ss_state_q;
        ss_cnt_d   = ss_cnt_q;
        ss_req_w   = 1'b0;
        rst_req_w  = 1'b0;
        case (ss_state_q)
            SS_IDLE: begin
                if (press_w[2]) begin
                    ss_state_d = SS_HELD;
                    // The press cycle itself is the first held cycle.
                    ss_cnt_d   = 16'd1;
                end
            end
            SS_HELD: begin
                if (btn_q[2]) begin
                    ss_req_w   = 1'b1;
                    ss_state_d = SS_IDLE;
                    ss_cnt_d   = 16'd0;
                end else if (ss_cnt_q >= long_press_count) begin
                    rst_req_w  = 1'b1;
                    ss_state_d = SS_LONG;
                    ss_cnt_d   = sat_inc(ss_cnt_q);
                end else begin
                    ss_cnt_d   = sat_inc(ss_cnt_q);
                end
            end
            SS_LONG: begin
                if (btn_q[2]) begin
                    ss_state_d = SS_IDLE;
                    ss_cnt_d   = 16'd0;
                end else begin
                    ss_cnt_d   = sat_inc(ss_cnt_q);
                end
            end
            default: begin
                ss_state_d = SS_IDLE;
                ss_cnt_d   = 16'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Increment buttons: one pulse on press, then auto-repeat while held.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inc
            inc_state_t  state_q;
            inc_state_t  state_d;
            logic [15:0] cnt_q;
            logic [15:0] cnt_d;
            logic        req;

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                req     = 1'b0;
                case (state_q)
                    INC_IDLE: begin
                        if (press_w[gi]) begin
                            req     = 1'b1;
                            state_d = INC_DELAY;
                            cnt_d   = 16'd1;
                        end
                    end
                    INC_DELAY: begin
                        if (btn_q[gi]) begin
                            state_d = INC_IDLE;
                            cnt_d   = 16'd0;
                        end else if (cnt_q >= repeat_delay) begin
                            req     = 1'b1;
                            state_d = INC_REPEAT;
                            cnt_d   = 16'd1;
                        end else begin
                            cnt_d   = sat_inc(cnt_q);
                        end
                    end
                    INC_REPEAT: begin
                        if (btn_q[gi]) begin
                            state_d = INC_IDLE;
                            cnt_d   = 16'd0;
                        end else if (cnt_q >= repeat_period) begin
                            req     = 1'b1;
                            cnt_d   = 16'd1;
                        end else begin
                            cnt_d   = sat_inc(cnt_q);
                        end
                    end
                    default: begin
                        state_d = INC_IDLE;
                        cnt_d   = 16'd0;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q <= INC_IDLE;
                    cnt_q   <= 16'd0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign inc_req_w[gi] = req;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Arbitration: requests posted this cycle are eligible for grant at once,
    // which gives one cycle from request to strobe.
    // -------------------------------------------------------------------------
    assign req_w      = {rst_req_w, ss_req_w, inc_req_w[1], inc_req_w[0]};
    assign pend_all_w = pend_q | req_w;

    always_comb begin
        grant_w = 4'b0000;
        if (pend_all_w[c_BIT_RESET]) begin
            grant_w[c_BIT_RESET] = 1'b1;
        end else if (pend_all_w[c_BIT_SS]) begin
            grant_w[c_BIT_SS] = 1'b1;
        end else if (pend_all_w[c_BIT_MIN]) begin
            grant_w[c_BIT_MIN] = 1'b1;
        end else if (pend_all_w[c_BIT_SEC]) begin
            grant_w[c_BIT_SEC] = 1'b1;
        end
    end

    assign pend_d = pend_all_w & ~grant_w;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q      <= 3'b111;
            btn_prev_q <= 3'b111;
            ss_state_q <= SS_IDLE;
            ss_cnt_q   <= 16'd0;
            pend_q     <= 4'b0000;
            strobe_q   <= 4'b0000;
        end else begin
            btn_q      <= {button_startstop_n, button_min_n, button_sec_n};
            btn_prev_q <= btn_q;
            ss_state_q <= ss_state_d;
            ss_cnt_q   <= ss_cnt_d;
            pend_q     <= pend_d;
            strobe_q   <= grant_w;
        end
    end

    assign ctrl_reset     = strobe_q[c_BIT_RESET];
    assign ctrl_startstop = strobe_q[c_BIT_SS];
    assign ctrl_incmin    = strobe_q[c_BIT_MIN];
    assign ctrl_incsec    = strobe_q[c_BIT_SEC];

endmodule
`default_nettype wire

// File: tb/tb_button_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_button_sequencer
// Purpose  : Directed self-checking bench for button_sequencer (8/6/3 timing).
// Revision : 1.0 - initial release
// =============================================================================
module tb_button_sequencer;

    logic clk;
    logic reset;
    logic button_startstop_n;
    logic button_min_n;
    logic button_sec_n;
    logic ctrl_startstop;
    logic ctrl_reset;
    logic ctrl_incmin;
    logic ctrl_incsec;

    int n_assert;
    int n_fail;

    // Expected strobes per cycle as {reset, startstop, incmin, incsec}.
    localparam logic [3:0] c_R = 4'b1000;
    localparam logic [3:0] c_S = 4'b0100;
    localparam logic [3:0] c_M = 4'b0010;
    localparam logic [3:0] c_C = 4'b0001;

    // Button levels to be registered in cycle c as {startstop, min, sec}.
    logic [2:0] sched [0:31];
    logic [3:0] exp_v [0:31];

    button_sequencer #(
        .long_press_count (16'd8),
        .repeat_delay     (16'd6),
        .repeat_period    (16'd3)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .button_startstop_n (button_startstop_n),
        .button_min_n       (button_min_n),
        .button_sec_n       (button_sec_n),
        .ctrl_startstop     (ctrl_startstop),
        .ctrl_reset         (ctrl_reset),
        .ctrl_incmin        (ctrl_incmin),
        .ctrl_incsec        (ctrl_incsec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int c, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {ctrl_reset, ctrl_startstop, ctrl_incmin, ctrl_incsec};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc %0d: observed %b expected %b", tag, c, obs, exp);
        end
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 32; i++) begin
            sched[i] = 3'b111;
            exp_v[i] = 4'b0000;
        end
    endtask

    task automatic hold(input int bit_idx, input int from, input int to);
        for (int c = from; c <= to; c++) sched[c][bit_idx] = 1'b0;
    endtask

    task automatic run_sched(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            {button_startstop_n, button_min_n, button_sec_n} = sched[c];
            @(posedge clk); #1;
            check(tag, c, exp_v[c]);
        end
    endtask

    task automatic idle(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            {button_startstop_n, button_min_n, button_sec_n} = 3'b111;
            @(posedge clk); #1;
            check(tag, c, 4'b0000);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        {button_startstop_n, button_min_n, button_sec_n} = 3'b111;
        #1;
        check("reset_state", 0, 4'b0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_held", 1, 4'b0000);
        reset = 1'b1;
        idle("post_reset_idle", 4);

        // Short start/stop press: strobe one cycle after release is registered.
        clear_tables();
        hold(2, 0, 2);
        exp_v[4] = c_S;
        run_sched("ss_short", 8);
        idle("gap1", 3);

        // Release just short of the long-press threshold.
        clear_tables();
        hold(2, 0, 6);
        exp_v[8] = c_S;
        run_sched("ss_edge7", 11);
        idle("gap2", 3);

        // Long press: one reset strobe, nothing on release.
        clear_tables();
        hold(2, 0, 19);
        exp_v[9] = c_R;
        run_sched("ss_long", 26);
        idle("gap3", 3);

        // Minute auto-repeat.
        clear_tables();
        hold(1, 0, 14);
        exp_v[1]  = c_M;
        exp_v[7]  = c_M;
        exp_v[10] = c_M;
        exp_v[13] = c_M;
        run_sched("min_repeat", 20);
        idle("gap4", 3);

        // Release during DELAY posts nothing further.
        clear_tables();
        hold(0, 0, 2);
        exp_v[1] = c_C;
        run_sched("sec_tap", 10);
        idle("gap5", 3);

        // Simultaneous presses serialise by priority.
        clear_tables();
        hold(1, 0, 1);
        hold(0, 0, 1);
        exp_v[1] = c_M;
        exp_v[2] = c_C;
        run_sched("min_sec_same", 6);
        idle("gap6", 3);

        // Long-press reset collides with a second repeat request at cycle 8.
        clear_tables();
        hold(2, 0, 11);
        hold(0, 2, 11);
        exp_v[3]  = c_C;
        exp_v[9]  = c_R;
        exp_v[10] = c_C;
        exp_v[12] = c_C;
        run_sched("reset_vs_sec", 16);
        idle("gap7", 3);

        // Asynchronous reset in the middle of a minute hold.
        clear_tables();
        hold(1, 0, 7);
        exp_v[1] = c_M;
        exp_v[7] = c_M;
        run_sched("min_pre_rst", 8);
        button_min_n = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_async", 0, 4'b0000);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            check("rst_hold", c, 4'b0000);
        end
        reset = 1'b1;

        // Still held at reset release: treated as a fresh press, timing restarts.
        clear_tables();
        hold(1, 0, 11);
        exp_v[1]  = c_M;
        exp_v[7]  = c_M;
        exp_v[10] = c_M;
        run_sched("min_post_rst", 14);
        idle("gap8", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
